alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU datapath between two requesters (port 0: integer execute, port 1: address/branch unit).

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_share_arbiter_if.sv | 32 +++
 rtl/alu.sv | 40 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_share_arbiter.sv | 85 ++++++++
 tb/tb_alu_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: opcode encoding, widths and the request payload type.
//   ALU_W       datapath width of the shared ALU
//   ALU_OP_W    opcode width
//   ALU_*       opcode values; ALU_OP_LAST is the highest defined code
//   alu_req_t   one requester's {op_a, op_b, alu_op} bundle
package alu_pkg;

  localparam int unsigned ALU_W    = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd9;

  localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 4'd9;

  typedef struct packed {
    logic [ALU_W-1:0]    op_a;
    logic [ALU_W-1:0]    op_b;
    logic [ALU_OP_W-1:0] alu_op;
  } alu_req_t;

  // Codes above ALU_OP_LAST are undefined and flagged as errors.
  function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] op);
    return op > ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-port request/response bundle for the shared ALU arbiter.
//   i_req_valid/o_req_ready   per-port request handshake (bit p = port p)
//   i_req_op_a/op_b           port p operand at [p*DATA_W +: DATA_W]
//   i_req_alu_op              port p opcode at [p*4 +: 4]
//   o_rsp_valid/i_rsp_ready   per-port response handshake
//   o_rsp_data/o_rsp_err      port p result and undefined-opcode flag
//   modport slave: the arbiter; modport master: the requesters
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
);

  logic [1:0]          i_req_valid;
  logic [1:0]          o_req_ready;
  logic [2*DATA_W-1:0] i_req_op_a;
  logic [2*DATA_W-1:0] i_req_op_b;
  logic [7:0]          i_req_alu_op;
  logic [1:0]          o_rsp_valid;
  logic [1:0]          i_rsp_ready;
  logic [2*DATA_W-1:0] o_rsp_data;
  logic [1:0]          o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU.
//   a, b  operands (N bits)
//   op    opcode from alu_pkg; undefined codes produce zero
//   y     result (N bits)
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [N-1:0]        y
);

  localparam int unsigned SH_W = $clog2(N);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  // Result select by opcode.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = N'($signed(a) < $signed(b));
      ALU_SLTU: y = N'(a < b);
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = N'($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n  clock and async active-low reset
//   elig        per-port eligibility
//   grant       one-hot or zero grant (combinational)
//   ptr         priority pointer: port favoured when both are eligible
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  output logic [1:0] grant,
  output logic       ptr
);

  // Pointer only breaks ties; a lone eligible port always wins.
  always_comb begin
    grant = elig;
    if (&elig) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Priority flips to the other port after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and
// a registered response slot per port.
//   i_clk, i_rst_n  clock and async active-low reset
//   bus             alu_share_arbiter_if.slave (request/response handshakes)
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned NPORT = 2;

  logic [1:0]        rsp_valid;
  logic [1:0]        free_c;
  logic [1:0]        elig_c;
  logic [1:0]        grant_c;
  logic              ptr;
  alu_req_t          req_c [NPORT];
  alu_req_t          sel_c;
  logic [DATA_W-1:0] alu_y_c;

  // A slot being drained this cycle can take a new result.
  assign free_c = ~rsp_valid | bus.i_rsp_ready;
  assign elig_c = bus.i_req_valid & free_c;

  rr_arb2 u_arb (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .elig  (elig_c),
    .grant (grant_c),
    .ptr   (ptr)
  );

  // Ready is suppressed for as long as reset is held.
  assign bus.o_req_ready = grant_c & {2{i_rst_n}};
  assign bus.o_rsp_valid = rsp_valid;

  // Port 0 drives the ALU when nothing is granted; that result is dropped.
  assign sel_c = grant_c[1] ? req_c[1] : req_c[0];

  alu #(.N(DATA_W)) u_alu (
    .a  (sel_c.op_a),
    .b  (sel_c.op_b),
    .op (sel_c.alu_op),
    .y  (alu_y_c)
  );

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    assign req_c[p] = {bus.i_req_op_a[p*DATA_W +: DATA_W],
                       bus.i_req_op_b[p*DATA_W +: DATA_W],
                       bus.i_req_alu_op[p*ALU_OP_W +: ALU_OP_W]};

    // Response slot: load on grant, clear on drain, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        err_q   <= 1'b0;
      end else if (grant_c[p]) begin
        valid_q <= 1'b1;
        data_q  <= alu_y_c;
        err_q   <= is_illegal_op(sel_c.alu_op);
      end else if (bus.i_rsp_ready[p]) begin
        valid_q <= 1'b0;
      end
    end

    assign rsp_valid[p]                       = valid_q;
    assign bus.o_rsp_data[p*DATA_W +: DATA_W] = data_q;
    assign bus.o_rsp_err[p]                   = err_q;
  end

  // Ties must go to the port named by the pointer.
  a_tie_follows_ptr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (&elig_c) |-> grant_c[ptr]);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  vld;
  logic [1:0]  rdy;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [3:0]  op [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic        m_ptr = 1'b0;

  alu_share_arbiter_if #(.DATA_W(DW)) bus ();

  assign bus.i_req_valid  = vld;
  assign bus.i_rsp_ready  = rdy;
  assign bus.i_req_op_a   = {a[1], a[0]};
  assign bus.i_req_op_b   = {b[1], b[0]};
  assign bus.i_req_alu_op = {op[1], op[0]};

  alu_share_arbiter #(.DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {err, data}.
  function automatic logic [32:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] o);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (o)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd3: r = (x < y) ? 32'd1 : 32'd0;
      4'd4: r = x ^ y;
      4'd5: r = x | y;
      4'd6: r = x & y;
      4'd7: r = x << y[4:0];
      4'd8: r = x >> y[4:0];
      4'd9: r = 32'($signed(x) >>> y[4:0]);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Scoreboard: slot contents are the head of each port's queue.
  always @(negedge clk) begin
    logic [1:0] mv, fr, el, eg;
    if (mon_en && rst_n) begin
      mv = {q1.size() != 0, q0.size() != 0};
      fr = ~mv | rdy;
      el = vld & fr;
      eg = (el == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : el;
      checks++;
      if (bus.o_req_ready !== eg) begin
        errors++;
        $display("FAIL sb_ready t=%0t: got %b expected %b", $time, bus.o_req_ready, eg);
      end
      checks++;
      if (bus.o_rsp_valid !== mv) begin
        errors++;
        $display("FAIL sb_rsp_valid t=%0t: got %b expected %b", $time, bus.o_rsp_valid, mv);
      end
      if (mv[0]) begin
        checks++;
        if ({bus.o_rsp_err[0], bus.o_rsp_data[31:0]} !== q0[0]) begin
          errors++;
          $display("FAIL sb_rsp0 t=%0t: got %h expected %h", $time,
                   {bus.o_rsp_err[0], bus.o_rsp_data[31:0]}, q0[0]);
        end
      end
      if (mv[1]) begin
        checks++;
        if ({bus.o_rsp_err[1], bus.o_rsp_data[63:32]} !== q1[0]) begin
          errors++;
          $display("FAIL sb_rsp1 t=%0t: got %h expected %h", $time,
                   {bus.o_rsp_err[1], bus.o_rsp_data[63:32]}, q1[0]);
        end
      end
      if (mv[0] && rdy[0]) void'(q0.pop_front());
      if (mv[1] && rdy[1]) void'(q1.pop_front());
      if (eg[0]) q0.push_back(alu_ref(a[0], b[0], op[0]));
      if (eg[1]) q1.push_back(alu_ref(a[1], b[1], op[1]));
      if (eg[0]) m_ptr = 1'b1;
      else if (eg[1]) m_ptr = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mon_en = 1'b0;
    q0.delete();
    q1.delete();
    m_ptr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    vld = 2'b11; rdy = 2'b11;
    a[0] = 32'd1;  b[0] = 32'd2;  op[0] = 4'd0;
    a[1] = 32'd6;  b[1] = 32'd3;  op[1] = 4'd4;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", bus.o_req_ready); end
    checks++;
    if (bus.o_rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", bus.o_rsp_valid); end
    checks++;
    if (bus.o_rsp_data !== 64'd0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0", bus.o_rsp_data); end
    checks++;
    if (bus.o_rsp_err !== 2'b00) begin errors++; $display("FAIL rst_rsp_err: got %b expected 00", bus.o_rsp_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b expected 01", bus.o_req_ready); end
    step();
    vld = 2'b00;
    repeat (2) step();
  endtask

  task automatic test_single();
    a[0] = 32'd5; b[0] = 32'd7; op[0] = 4'd0;
    vld = 2'b01; rdy = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL single_ready0: got %b expected 01", bus.o_req_ready); end
    step();
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.o_rsp_valid[0], bus.o_rsp_err[0], bus.o_rsp_data[31:0]} !== {1'b1, 1'b0, 32'd12}) begin
      errors++;
      $display("FAIL single_rsp0: got v=%b e=%b d=%h expected v=1 e=0 d=0000000c",
               bus.o_rsp_valid[0], bus.o_rsp_err[0], bus.o_rsp_data[31:0]);
    end
    a[1] = 32'hFF00FF00; b[1] = 32'h0F0F0F0F; op[1] = 4'd4;
    step();
    vld = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL single_ready1: got %b expected 10", bus.o_req_ready); end
    step();
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.o_rsp_data[63:32] !== 32'hF00FF00F) begin
      errors++; $display("FAIL single_rsp1: got %h expected f00ff00f", bus.o_rsp_data[63:32]);
    end
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    a[0] = 32'd3;          b[0] = 32'd5; op[0] = 4'd1;
    a[1] = 32'h80000000;   b[1] = 32'd4; op[1] = 4'd9;
    vld = 2'b11; rdy = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (bus.o_req_ready !== exp_g) begin
        errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, bus.o_req_ready, exp_g);
      end
      if (i >= 2) begin
        checks++;
        if (bus.o_rsp_data !== {32'hF8000000, 32'hFFFFFFFE}) begin
          errors++; $display("FAIL contention_data[%0d]: got %h expected f8000000fffffffe", i, bus.o_rsp_data);
        end
      end
      step();
    end
    vld = 2'b00;
    repeat (2) step();
  endtask

  task automatic test_backpressure();
    a[1] = 32'd1; b[1] = 32'hFFFFFFFF; op[1] = 4'd3;
    vld = 2'b10; rdy = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL bp_first_ready: got %b expected 10", bus.o_req_ready); end
    step();
    vld = 2'b00; rdy = 2'b01;
    @(negedge clk);
    checks++;
    if ({bus.o_rsp_valid[1], bus.o_rsp_data[63:32]} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL bp_sltu: got v=%b d=%h expected v=1 d=00000001",
                         bus.o_rsp_valid[1], bus.o_rsp_data[63:32]);
    end
    a[1] = 32'd100; b[1] = 32'd200; op[1] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a[0] = 32'h100 << i; b[0] = 32'(i); op[0] = 4'd5;
      vld = 2'b11;
      @(negedge clk);
      checks++;
      if (bus.o_req_ready !== 2'b01) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected 01", i, bus.o_req_ready);
      end
      checks++;
      if ({bus.o_rsp_valid[1], bus.o_rsp_err[1], bus.o_rsp_data[63:32]} !== {1'b1, 1'b0, 32'd1}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b e=%b d=%h expected v=1 e=0 d=00000001", i,
                           bus.o_rsp_valid[1], bus.o_rsp_err[1], bus.o_rsp_data[63:32]);
      end
      step();
    end
    rdy = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL bp_reload_ready: got %b expected 10", bus.o_req_ready); end
    step();
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.o_rsp_valid[1], bus.o_rsp_data[63:32]} !== {1'b1, 32'd300}) begin
      errors++; $display("FAIL bp_reload_data: got v=%b d=%h expected v=1 d=0000012c",
                         bus.o_rsp_valid[1], bus.o_rsp_data[63:32]);
    end
    repeat (2) step();
  endtask

  task automatic test_illegal();
    a[0] = 32'd9; b[0] = 32'd9; op[0] = 4'd12;
    vld = 2'b01; rdy = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL illegal_ready: got %b expected 01", bus.o_req_ready); end
    step();
    a[0] = 32'd1;  b[0] = 32'd1;  op[0] = 4'd0;
    a[1] = 32'hF0; b[1] = 32'h3C; op[1] = 4'd6;
    vld = 2'b11;
    @(negedge clk);
    checks++;
    if ({bus.o_rsp_err[0], bus.o_rsp_data[31:0]} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL illegal_rsp: got e=%b d=%h expected e=1 d=00000000",
                         bus.o_rsp_err[0], bus.o_rsp_data[31:0]);
    end
    checks++;
    if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL illegal_ptr: got %b expected 10", bus.o_req_ready); end
    step();
    vld = 2'b00;
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    a[1] = 32'd2; b[1] = 32'd3; op[1] = 4'd0;
    vld = 2'b10; rdy = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b10) begin errors++; $display("FAIL ar_fill1: got %b expected 10", bus.o_req_ready); end
    step();
    a[0] = 32'd4; b[0] = 32'd4; op[0] = 4'd0;
    vld = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL ar_fill0: got %b expected 01", bus.o_req_ready); end
    step();
    vld = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.o_rsp_valid !== 2'b11) begin errors++; $display("FAIL ar_full: got %b expected 11", bus.o_rsp_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.o_rsp_valid, bus.o_req_ready} !== 4'b0000) begin
      errors++; $display("FAIL ar_clear: got valid=%b ready=%b expected 00/00", bus.o_rsp_valid, bus.o_req_ready);
    end
    checks++;
    if (bus.o_rsp_data !== 64'd0) begin errors++; $display("FAIL ar_data: got %h expected 0", bus.o_rsp_data); end
    vld = 2'b11; rdy = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    checks++;
    if (bus.o_req_ready !== 2'b01) begin errors++; $display("FAIL ar_ptr: got %b expected 01", bus.o_req_ready); end
    step();
    vld = 2'b00;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_async_reset();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
